pipe_stage_skid: RTL
====================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. It carries an opaque bundle of stage fields (instr, pc, immediate, operands) from one pipeline stage to the next. It supports back-pressure without a combinational ready path, synchronous flush with bubble insertion, and a saturating stall counter. It sits between any two CPU stages (F/D, D/E, E/M, M/W) and supersedes the fixed-width, enable-only stage registers.

## Interface
- `DATA_W`, default 160: width of the carried bundle (for example 5 × 32-bit fields).
- `CNT_W`, default 16: width of the stall counter.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous active-low reset (0 = reset).
- `in_valid`  input  1  upstream presents an item.
- `in_ready`  output  1  stage can accept; driven from state only.
- `in_data`  input  DATA_W  upstream bundle.
- `out_valid`  output  1  stage holds a valid item.
- `out_ready`  input  1  downstream accepts.
- `out_data`  output  DATA_W  bundle of the oldest held item; all-zero (bubble/nop) when `out_valid` = 0.
- `flush`  input  1  synchronous kill of all held and incoming items.
- `cnt_clr`  input  1  synchronous clear of `stall_cnt`.
- `stall_cnt`  output  CNT_W  count of cycles with `out_valid` && !`out_ready`.

## Operation
- push = `in_valid` && `in_ready`; pop = `out_valid` && `out_ready`.
- Storage is two registers: `main` (head, drives `out_data`) and `skid` (overflow). FIFO order is always preserved.
- State machine with three states:
  - EMPTY: `in_ready`=1, `out_valid`=0. On push, go to ONE and set `main`←`in_data`.
  - ONE: `in_ready`=1, `out_valid`=1.
    - push && pop: stay in ONE, `main`←`in_data`.
    - push only: go to FULL, `skid`←`in_data`.
    - pop only: go to EMPTY, `main`←0.
    - neither: hold.
  - FULL: `in_ready`=0, `out_valid`=1.
    - pop: go to ONE, `main`←`skid`, `skid`←0.
    - otherwise: hold.
- `flush`=1 has priority over push and pop:
  - Next state is EMPTY; `main` and `skid` are set to 0.
  - An item presented with `in_valid` in the flush cycle is discarded, even though `in_ready` may be 1.
- `stall_cnt`:
  - Increments by 1 each cycle with `out_valid` && !`out_ready`.
  - Saturates at 2^CNT_W−1 (no wrap).
  - `cnt_clr` forces it to 0; `cnt_clr` wins over a simultaneous increment.
  - `flush` does not affect it.
- A register outside the valid entries is always zero, so an invalid `out_data` is a nop bundle.

## Timing
- Reset (`rst`=0, asynchronous, any time including mid-transfer):
  - State becomes EMPTY; `main` and `skid` become 0.
  - Outputs: `in_ready`=1, `out_valid`=0, `out_data`=0, `stall_cnt`=0.
  - Release is taken at the next rising edge with `rst`=1.
- Latency is 1 cycle: an item pushed at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- Throughput is 1 item/cycle when `out_ready` is held high; `skid` stays unused in that case.
- `in_ready` is a registered function of state, with no combinational path from `out_ready`.
- `in_ready` falls in the cycle after the push that fills `skid`, and rises in the cycle after the pop from FULL.
- `out_valid` and `out_data` are stable while `out_valid` && !`out_ready`; the item is held until popped.
- `flush` takes effect at the edge it is sampled on: `out_valid`=0 and `in_ready`=1 in the following cycle.

## Test plan
- Reset mid-stream:
  - Stimulus: push 0xA5 with `rst` deasserted, then assert `rst`=0 asynchronously between edges.
  - Required: `out_valid`, `out_data` and `stall_cnt` drop to 0 immediately, without waiting for a clock edge; `in_ready`=1.
- Streaming:
  - Stimulus: push items 1, 2, 3, 4 on consecutive cycles with `out_ready`=1.
  - Required: `out_data` = 1, 2, 3, 4 on consecutive cycles starting 1 cycle after the first push; `in_ready` stays 1 throughout.
- Back-pressure fill:
  - Stimulus: `out_ready`=0, push 0x11 then 0x22.
  - Required: `in_ready`=0 after the second push; `out_data` holds 0x11.
  - Stimulus continues: raise `out_ready` for 2 cycles.
  - Required: outputs 0x11 then 0x22, `in_ready` returns to 1, and `stall_cnt` equals the number of stalled cycles (2 for one idle cycle between fill and release).
- Flush with simultaneous push:
  - Stimulus: state FULL (0x11, 0x22), then assert `flush` and push 0x33 in the same cycle.
  - Required: the next cycle shows `out_valid`=0, `out_data`=0, `in_ready`=1; 0x33 never appears on the output.
- Counter saturation and clear:
  - Stimulus: `CNT_W`=4, hold `out_valid` with `out_ready`=0 for 20 cycles.
  - Required: `stall_cnt` stops at 15.
  - Stimulus continues: pulse `cnt_clr` during an ongoing stall.
  - Required: `stall_cnt`=0 next cycle, then resumes counting 1, 2, ….
- Random valid/ready:
  - Stimulus: 10k cycles of random `in_valid`/`out_ready`/`flush` against a FIFO reference model.
  - Required: identical output order and no loss except flushed items.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready/out_valid come straight from flops; empty entries are kept at zero so an idle output is a nop.
module pipe_stage_skid #(
  parameter int DATA_W = 160,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_r, state_s;
  logic [DATA_W-1:0] main_r, main_s;
  logic [DATA_W-1:0] skid_r, skid_s;
  logic              in_ready_r, in_ready_s;
  logic              out_valid_r, out_valid_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              push_s, pop_s;

  // Next-state, storage and handshake-flag computation; flush overrides push and pop.
  always_comb begin
    state_s = state_r;
    main_s  = main_r;
    skid_s  = skid_r;
    push_s  = in_valid && in_ready_r;
    pop_s   = out_valid_r && out_ready;
    if (flush) begin
      state_s = ST_EMPTY;
      main_s  = {DATA_W{1'b0}};
      skid_s  = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (push_s) begin
            state_s = ST_ONE;
            main_s  = in_data;
          end else begin
            state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            main_s = in_data;
          end else if (push_s) begin
            state_s = ST_FULL;
            skid_s  = in_data;
          end else if (pop_s) begin
            state_s = ST_EMPTY;
            main_s  = {DATA_W{1'b0}};
          end else begin
            state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (pop_s) begin
            state_s = ST_ONE;
            main_s  = skid_r;
            skid_s  = {DATA_W{1'b0}};
          end else begin
            state_s = ST_FULL;
          end
        end
        default: begin
          state_s = ST_EMPTY;
          main_s  = {DATA_W{1'b0}};
          skid_s  = {DATA_W{1'b0}};
        end
      endcase
    end
    in_ready_s  = (state_s != ST_FULL);
    out_valid_s = (state_s != ST_EMPTY);
  end

  // State, storage and registered handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_EMPTY;
      main_r      <= {DATA_W{1'b0}};
      skid_r      <= {DATA_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      main_r      <= main_s;
      skid_r      <= skid_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  // Saturating stall counter; clear beats increment, flush leaves it alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (out_valid_r && !out_ready && (cnt_r != CNT_MAX)) begin
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = main_r;
  assign stall_cnt = cnt_r;

endmodule
